// File: rtl/sd_resp_if.sv
// Bus between the SD host controller (master) and the CMD-line response receiver (slave).
interface sd_resp_if;
    logic         sd_clk_en;
    logic         sd_cmd;
    logic         start;
    logic [1:0]   resp_type;
    logic [5:0]   exp_index;
    logic         abort;
    logic         busy;
    logic         resp_valid;
    logic [5:0]   resp_index;
    logic [127:0] resp_data;
    logic         crc_err;
    logic         index_err;
    logic         frame_err;
    logic         timeout_err;

    modport master (
        output sd_clk_en, sd_cmd, start, resp_type, exp_index, abort,
        input  busy, resp_valid, resp_index, resp_data,
               crc_err, index_err, frame_err, timeout_err
    );

    modport slave (
        input  sd_clk_en, sd_cmd, start, resp_type, exp_index, abort,
        output busy, resp_valid, resp_index, resp_data,
               crc_err, index_err, frame_err, timeout_err
    );
endinterface

// File: rtl/sd_resp_receiver.sv
// SD CMD-line response receiver: frames one 48-bit (R1/R3/R6/R7) or 136-bit (R2)
// response sampled on SD-clock strobes, checks CRC7, index, framing and Ncr timeout.
module sd_resp_receiver #(
    parameter int TIMEOUT_TICKS = 64,
    parameter int TO_W          = 8,
    parameter bit CHECK_END     = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    sd_resp_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_RECV       = 3'd2,
        S_CHECK      = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [1:0]      TYPE_NONE = 2'd0;
    localparam logic [1:0]      TYPE_R1   = 2'd1;
    localparam logic [1:0]      TYPE_R3   = 2'd2;
    localparam logic [1:0]      TYPE_R2   = 2'd3;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

    // One serial step of CRC7, generator x^7 + x^3 + 1, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [5:0]      exp_idx_q, exp_idx_d;
    logic            long_q, long_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      bit_cnt_q, bit_cnt_d;
    logic [134:0]    shift_q, shift_d;
    logic [6:0]      crc_q, crc_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [5:0]      index_q, index_d;
    logic [127:0]    data_q, data_d;
    logic            crc_err_q, crc_err_d;
    logic            idx_err_q, idx_err_d;
    logic            frm_err_q, frm_err_d;
    logic            to_err_q, to_err_d;
    logic            tx_bit_s;

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        exp_idx_d = exp_idx_q;
        long_d    = long_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        valid_d   = 1'b0;
        index_d   = index_q;
        data_d    = data_q;
        crc_err_d = crc_err_q;
        idx_err_d = idx_err_q;
        frm_err_d = frm_err_q;
        to_err_d  = to_err_q;
        tx_bit_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    type_d    = bus.resp_type;
                    exp_idx_d = bus.exp_index;
                    long_d    = (bus.resp_type == TYPE_R2);
                    to_cnt_d  = {TO_W{1'b0}};
                    index_d   = 6'd0;
                    data_d    = 128'd0;
                    crc_err_d = 1'b0;
                    idx_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    to_err_d  = 1'b0;
                    if (bus.resp_type == TYPE_NONE) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_START: begin
                if (bus.sd_clk_en) begin
                    if (!bus.sd_cmd) begin
                        // Start bit is zero, so a cleared CRC already accounts for it.
                        shift_d   = 135'd0;
                        crc_d     = 7'd0;
                        bit_cnt_d = long_q ? 8'd134 : 8'd46;
                        state_d   = S_RECV;
                    end else if (to_cnt_q == TO_LAST) begin
                        to_err_d = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end else begin
                    state_d = S_WAIT_START;
                end
            end

            S_RECV: begin
                if (bus.sd_clk_en) begin
                    shift_d = {shift_q[133:0], bus.sd_cmd};
                    // bit_cnt equals the frame bit index; R2 restarts CRC at bit 127.
                    if (bit_cnt_q >= 8'd8) begin
                        crc_d = crc7_step((long_q && (bit_cnt_q == 8'd127)) ? 7'd0 : crc_q,
                                          bus.sd_cmd);
                    end else begin
                        crc_d = crc_q;
                    end
                    if (bit_cnt_q == 8'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 8'd1;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end

            S_CHECK: begin
                if (long_q) begin
                    index_d  = shift_q[133:128];
                    data_d   = {shift_q[127:1], 1'b0};
                    tx_bit_s = shift_q[134];
                end else begin
                    index_d  = shift_q[45:40];
                    data_d   = {96'd0, shift_q[39:8]};
                    tx_bit_s = shift_q[46];
                end
                frm_err_d = tx_bit_s | (CHECK_END & ~shift_q[0]);
                crc_err_d = (type_q != TYPE_R3) && (crc_q != shift_q[7:1]);
                idx_err_d = (type_q == TYPE_R1) && (index_d != exp_idx_q);
                valid_d   = 1'b1;
                state_d   = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            index_d   = 6'd0;
            data_d    = 128'd0;
            crc_err_d = 1'b0;
            idx_err_d = 1'b0;
            frm_err_d = 1'b0;
            to_err_d  = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            type_q    <= 2'd0;
            exp_idx_q <= 6'd0;
            long_q    <= 1'b0;
            to_cnt_q  <= {TO_W{1'b0}};
            bit_cnt_q <= 8'd0;
            shift_q   <= 135'd0;
            crc_q     <= 7'd0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            index_q   <= 6'd0;
            data_q    <= 128'd0;
            crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            exp_idx_q <= exp_idx_d;
            long_q    <= long_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            data_q    <= data_d;
            crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d;
            frm_err_q <= frm_err_d;
            to_err_q  <= to_err_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.resp_valid  = valid_q;
    assign bus.resp_index  = index_q;
    assign bus.resp_data   = data_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.index_err   = idx_err_q;
    assign bus.frame_err   = frm_err_q;
    assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Directed bench for sd_resp_receiver: frames are built bit-by-bit and the expected
// response is derived from the frame contents with a polynomial-division CRC model.
module tb_sd_resp_receiver;
    logic clk = 1'b0;
    logic reset;
    sd_resp_if bus();

    sd_resp_receiver #(.TIMEOUT_TICKS(64), .TO_W(8), .CHECK_END(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Expected DUT outputs for the current cycle.
    logic         m_busy, m_valid, m_crc, m_idx, m_frm, m_to;
    logic [5:0]   m_index;
    logic [127:0] m_data;
    // Expected result of the frame in flight.
    logic         e_crc, e_idx, e_frm;
    logic [5:0]   e_index;
    logic [127:0] e_data;

    task automatic cmp(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy",        136'(bus.busy),        136'(m_busy));
            cmp("resp_valid",  136'(bus.resp_valid),  136'(m_valid));
            cmp("resp_index",  136'(bus.resp_index),  136'(m_index));
            cmp("resp_data",   136'(bus.resp_data),   136'(m_data));
            cmp("crc_err",     136'(bus.crc_err),     136'(m_crc));
            cmp("index_err",   136'(bus.index_err),   136'(m_idx));
            cmp("frame_err",   136'(bus.frame_err),   136'(m_frm));
            cmp("timeout_err", 136'(bus.timeout_err), 136'(m_to));
        end
    end

    // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] crc_of(input logic [135:0] f, input int hi, input int lo);
        logic [134:0] d;
        int n;
        d = 135'd0;
        n = hi - lo + 1;
        for (int k = 0; k < n; k++) d[k + 7] = f[lo + k];
        for (int k = n + 6; k >= 7; k--) begin
            if (d[k]) d[k -: 8] = d[k -: 8] ^ 8'h89;
        end
        return d[6:0];
    endfunction

    function automatic logic [135:0] mk48(input logic [39:0] hdr, input logic endb);
        return {88'd0, hdr, crc_of({88'd0, hdr, 8'd0}, 47, 8), endb};
    endfunction

    task automatic calc(input logic [1:0] t, input logic [5:0] e, input logic [135:0] f);
        logic crc_ok;
        if (t == 2'd3) begin
            e_index = f[133:128];
            e_data  = {f[127:1], 1'b0};
            crc_ok  = (crc_of(f, 127, 8) == f[7:1]);
            e_frm   = f[134] | ~f[0];
        end else begin
            e_index = f[45:40];
            e_data  = {96'd0, f[39:8]};
            crc_ok  = (crc_of(f, 47, 8) == f[7:1]);
            e_frm   = f[46] | ~f[0];
        end
        e_crc = (t != 2'd2) && !crc_ok;
        e_idx = (t == 2'd1) && (f[45:40] != e);
    endtask

    task automatic model_zero();
        m_busy = 1'b0; m_valid = 1'b0; m_index = 6'd0; m_data = 128'd0;
        m_crc = 1'b0; m_idx = 1'b0; m_frm = 1'b0; m_to = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic en, input logic cmd);
        bus.sd_clk_en = en;
        bus.sd_cmd    = cmd;
        cyc();
        bus.sd_clk_en = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] t, input logic [5:0] e);
        bus.start = 1'b1; bus.resp_type = t; bus.exp_index = e;
        cyc();
        bus.start = 1'b0; bus.resp_type = 2'($urandom); bus.exp_index = 6'($urandom);
        model_zero();
        m_busy  = 1'b1;
        m_valid = (t == 2'd0);
    endtask

    task automatic send_frame(input logic [1:0] t, input logic [5:0] e, input logic [135:0] f,
                              input int ncr, input int gap, input int hijack);
        int len;
        len = (t == 2'd3) ? 136 : 48;
        calc(t, e, f);
        do_start(t, e);
        repeat (ncr) tick(1'b1, 1'b1);
        for (int i = len - 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom));
            if (i == hijack) begin
                bus.start = 1'b1; bus.resp_type = 2'd3; bus.exp_index = 6'd0;
            end
            tick(1'b1, f[i]);
            bus.start = 1'b0;
        end
        tick(1'b0, 1'b1);
        m_valid = 1'b1; m_index = e_index; m_data = e_data;
        m_crc = e_crc; m_idx = e_idx; m_frm = e_frm; m_to = 1'b0;
        tick(1'b0, 1'b1);
        m_busy = 1'b0; m_valid = 1'b0;
        tick(1'b0, 1'b1);
    endtask

    logic [135:0] fr1, fr2, fr3;
    logic [119:0] payload;

    initial begin
        bus.sd_clk_en = 1'b0; bus.sd_cmd = 1'b1; bus.start = 1'b0;
        bus.resp_type = 2'd0; bus.exp_index = 6'd0; bus.abort = 1'b0;
        reset = 1'b1;
        model_zero();
        cyc();
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

        // Model pins against hand-computed values.
        fr1 = 136'h3700000000F1;
        cmp("pin_crc_cmd55", 136'(crc_of(fr1, 47, 8)), 136'h78);
        cmp("pin_mk48_cmd55", mk48({2'b00, 6'd55, 32'd0}, 1'b1), 136'h3700000000F1);
        fr3 = 136'h3F80FF8000FF;
        calc(2'd2, 6'd0, fr3);
        cmp("pin_r3_data", 136'(e_data), 136'h80FF8000);
        cmp("pin_r3_crc", 136'(e_crc), 136'h0);

        // Type 0: straight to DONE.
        do_start(2'd0, 6'd0);
        tick(1'b0, 1'b1);
        m_busy = 1'b0; m_valid = 1'b0;
        tick(1'b0, 1'b1);

        send_frame(2'd1, 6'd55, fr1, 2, 0, -1);
        send_frame(2'd1, 6'd55, 136'h3700000000F3, 1, 1, -1);
        send_frame(2'd1, 6'd17, fr1, 0, 2, -1);
        send_frame(2'd2, 6'd0, fr3, 3, 0, -1);

        payload = 120'h0123456789ABCDEF0123456789ABCD;
        fr2 = {2'b00, 6'h3F, payload, 7'd0, 1'b1};
        fr2[7:1] = crc_of(fr2, 127, 8);
        calc(2'd3, 6'd0, fr2);
        cmp("pin_r2_payload", 136'(e_data[127:8]), 136'(payload));
        send_frame(2'd3, 6'd0, fr2, 1, 0, -1);
        send_frame(2'd3, 6'd0, fr2 ^ (136'd1 << 60), 2, 1, -1);

        send_frame(2'd1, 6'd55, 136'h3700000000F0, 1, 0, -1);
        send_frame(2'd1, 6'd55, mk48({2'b01, 6'd55, 32'd0}, 1'b1), 1, 1, -1);

        // Ncr timeout after 64 idle ticks, with ignored garbage between ticks.
        do_start(2'd1, 6'd55);
        for (int k = 1; k <= 64; k++) begin
            if (k % 3 == 0) tick(1'b0, 1'b0);
            tick(1'b1, 1'b1);
            if (k == 64) begin
                m_valid = 1'b1; m_to = 1'b1;
            end
        end
        tick(1'b0, 1'b1);
        m_busy = 1'b0; m_valid = 1'b0;
        tick(1'b0, 1'b1);

        // Abort 20 ticks into RECV; remaining bits must be ignored.
        do_start(2'd1, 6'd55);
        tick(1'b1, 1'b1);
        for (int i = 47; i >= 27; i--) tick(1'b1, fr1[i]);
        bus.abort = 1'b1;
        tick(1'b1, fr1[26]);
        bus.abort = 1'b0;
        model_zero();
        for (int i = 25; i >= 0; i--) tick(1'b1, fr1[i]);
        repeat (3) tick(1'b0, 1'b1);

        // Abort beats a simultaneous start.
        bus.abort = 1'b1; bus.start = 1'b1; bus.resp_type = 2'd1; bus.exp_index = 6'd55;
        cyc();
        bus.abort = 1'b0; bus.start = 1'b0;
        repeat (3) tick(1'b1, 1'b0);

        // Reset in WAIT_START.
        do_start(2'd1, 6'd55);
        repeat (5) tick(1'b1, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_zero();
        repeat (3) tick(1'b1, 1'b0);

        // Good R1 afterwards, with a start pulse while busy that must be ignored.
        send_frame(2'd1, 6'd55, fr1, 1, 0, 20);

        // Held outputs clear on abort in IDLE.
        send_frame(2'd1, 6'd17, fr1, 0, 0, -1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        model_zero();
        tick(1'b0, 1'b1);

        // Held outputs clear on reset.
        send_frame(2'd3, 6'd0, fr2, 0, 0, -1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_zero();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
